// File: rtl/register_bank_pkg.sv
// Shared widths and types for the register-file destination-select decoder.
package register_bank_pkg;

  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;

  typedef logic [ADDR_W-1:0]   reg_idx_t;
  typedef logic [NUM_REGS-1:0] reg_sel_t;

endpackage

// File: rtl/register_bank_onehot_decoder.sv
// Combinational binary-to-one-hot decoder; all-zero output when en is low.
module onehot_decoder
  import register_bank_pkg::*;
(
  input  logic [ADDR_W-1:0]   idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] sel
);

  always_comb begin
    sel = '0;
    if (en) begin
      sel[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/register_bank.sv
// Registered destination-select decoder driving the register-file write enables.
// Build option: define ZERO_REG_EN to make register 0 a hardwired zero register.
module register_bank
  import register_bank_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   destination,
  input  logic                enable,
  output logic [NUM_REGS-1:0] registerAddress,
  output logic                valid
);

  reg_idx_t dec_idx;
  reg_sel_t dec_sel;
  reg_sel_t masked_sel;

  assign dec_idx = destination;

  onehot_decoder u_decoder (
    .idx (dec_idx),
    .en  (enable),
    .sel (dec_sel)
  );

`ifdef ZERO_REG_EN
  // Register 0 is never write-selected; a request for it produces no selection.
  assign masked_sel = {dec_sel[NUM_REGS-1:1], 1'b0};
`else
  assign masked_sel = dec_sel;
`endif

  // valid is high exactly when registerAddress carries one selected bit;
  // there is no ready/back-pressure, a new selection is taken every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      registerAddress <= '0;
      valid           <= 1'b0;
    end else begin
      registerAddress <= masked_sel;
      valid           <= |masked_sel;
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Randomized and directed bench for register_bank against a behavioural select model.
module tb_register_bank;

  logic        clk;
  logic        rst_n;
  logic [3:0]  destination;
  logic        enable;
  logic [15:0] registerAddress;
  logic        valid;

  int n_checks;
  int n_passed;

  logic [15:0] exp_q[$];

  register_bank dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .destination     (destination),
    .enable          (enable),
    .registerAddress (registerAddress),
    .valid           (valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    destination = '0;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed === expected) begin
      n_passed++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: which register is written, as a number, then as a select word.
  function automatic logic [15:0] ref_sel(input logic rst, input logic en, input int dest);
    int v;
    if (!rst || !en) return 16'd0;
`ifdef ZERO_REG_EN
    if (dest == 0) return 16'd0;
`endif
    v = 1;
    for (int k = 0; k < dest; k++) v = v * 2;
    return v[15:0];
  endfunction

  // driver + scoreboard: apply one cycle of inputs, then check the lagged outputs
  task automatic step(input logic rst, input logic en, input int dest, input string tag);
    logic [15:0] exp_sel;
    @(negedge clk);
    rst_n       = rst;
    enable      = en;
    destination = dest[3:0];
    exp_q.push_back(ref_sel(rst, en, dest));
    @(posedge clk);
    #1;
    exp_sel = exp_q.pop_front();
    check({tag, ".sel"}, {16'd0, registerAddress}, {16'd0, exp_sel});
    check({tag, ".valid"}, {31'd0, valid}, {31'd0, (exp_sel != 16'd0)});
    check({tag, ".onehot"}, $countones(registerAddress), {31'd0, valid});
  endtask

  initial begin
    logic [15:0] lit;
    n_checks = 0;
    n_passed = 0;

    // reset held with an active request
    step(1'b0, 1'b1, 5, "reset0");
    check("reset0_zero", {16'd0, registerAddress}, 32'd0);
    step(1'b0, 1'b1, 5, "reset1");
    step(1'b1, 1'b1, 5, "release");
    check("release_lit", {16'd0, registerAddress}, 32'h0020);

    // full sweep, consecutive cycles
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, i, $sformatf("sweep%0d", i));
    end
    check("sweep15_lit", {16'd0, registerAddress}, 32'h8000);

    // enable gating
    step(1'b1, 1'b1, 9, "gate_on0");
    check("gate_on0_lit", {16'd0, registerAddress}, 32'h0200);
    step(1'b1, 1'b0, 9, "gate_off");
    check("gate_off_lit", {16'd0, registerAddress}, 32'h0000);
    step(1'b1, 1'b1, 9, "gate_on1");

    // reset pulse in the middle of a sweep
    for (int i = 0; i < 10; i++) begin
      step((i == 7) ? 1'b0 : 1'b1, 1'b1, i, $sformatf("midrst%0d", i));
      if (i == 8) check("midrst8_lit", {16'd0, registerAddress}, 32'h0100);
    end

    // boundary: 15 then 0 back-to-back
    step(1'b1, 1'b1, 15, "bound15");
    step(1'b1, 1'b1, 0, "bound0");
`ifdef ZERO_REG_EN
    lit = 16'h0000;
`else
    lit = 16'h0001;
`endif
    check("bound0_lit", {16'd0, registerAddress}, {16'd0, lit});
    step(1'b1, 1'b1, 1, "dest1");
    check("dest1_lit", {16'd0, registerAddress}, 32'h0002);

    // random traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 15)), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got stuck, expected summary");
    $fatal(1);
  end

endmodule
